// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch front end: cache request hold, one-entry skid, redirect drain
module fetch_unit #(
  parameter int                 A_WIDTH  = 32,
  parameter logic [A_WIDTH-1:0] RESET_PC = A_WIDTH'(32'hBFC0_0000)
) (
  input  logic               clk,
  input  logic               rst,
  output logic [A_WIDTH-1:0] p_a,
  output logic               p_strobe,
  input  logic [31:0]        p_din,
  input  logic               p_ready,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [A_WIDTH-1:0] redirect_pc,
  output logic               inst_valid,
  output logic [31:0]        inst,
  output logic [A_WIDTH-1:0] inst_pc,
  output logic               inst_adel
);

  typedef enum logic [2:0] {BOOT, FETCH, HOLD, DRAIN, HALT} state_t;

  state_t             state_q, state_d;
  logic [A_WIDTH-1:0] pc_q, pc_d;
  logic [A_WIDTH-1:0] fa_q, fa_d;
  logic               inflight_q, inflight_d;
  logic [31:0]        skid_inst_q, skid_inst_d;
  logic [A_WIDTH-1:0] skid_pc_q, skid_pc_d;
  logic               skid_valid_q, skid_valid_d;
  logic               out_valid_q, out_valid_d;
  logic [31:0]        out_inst_q, out_inst_d;
  logic [A_WIDTH-1:0] out_pc_q, out_pc_d;
  logic               out_adel_q, out_adel_d;

  logic               strobe;
  logic               slot_free;
  logic               can_issue;
  logic [A_WIDTH-1:0] req_a;

  // An outstanding request keeps presenting its original address until the cache answers.
  assign req_a     = inflight_q ? fa_q : pc_q;
  assign slot_free = ~out_valid_q | ~stall;
  assign can_issue = ~inflight_q & ~skid_valid_q & slot_free;

  assign p_a        = req_a;
  assign p_strobe   = strobe & ~rst;
  assign inst_valid = out_valid_q;
  assign inst       = out_inst_q;
  assign inst_pc    = out_pc_q;
  assign inst_adel  = out_adel_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    fa_d         = fa_q;
    inflight_d   = inflight_q;
    skid_inst_d  = skid_inst_q;
    skid_pc_d    = skid_pc_q;
    skid_valid_d = skid_valid_q;
    out_valid_d  = out_valid_q;
    out_inst_d   = out_inst_q;
    out_pc_d     = out_pc_q;
    out_adel_d   = out_adel_q;
    strobe       = 1'b0;

    if (out_valid_q && !stall) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      BOOT: state_d = FETCH;
      FETCH: begin
        if (inflight_q || (can_issue && pc_q[1:0] == 2'b00)) begin
          strobe     = 1'b1;
          fa_d       = req_a;
          inflight_d = ~p_ready;
          if (p_ready) begin
            pc_d = req_a + A_WIDTH'(4);
            if (slot_free) begin
              out_valid_d = 1'b1;
              out_inst_d  = p_din;
              out_pc_d    = req_a;
              out_adel_d  = 1'b0;
            end else begin
              skid_valid_d = 1'b1;
              skid_inst_d  = p_din;
              skid_pc_d    = req_a;
              state_d      = HOLD;
            end
          end
        end else if (can_issue) begin
          out_valid_d = 1'b1;
          out_inst_d  = '0;
          out_pc_d    = pc_q;
          out_adel_d  = 1'b1;
          state_d     = HALT;
        end
      end
      HOLD: begin
        if (!stall) begin
          out_valid_d  = 1'b1;
          out_inst_d   = skid_inst_q;
          out_pc_d     = skid_pc_q;
          out_adel_d   = 1'b0;
          skid_valid_d = 1'b0;
          state_d      = FETCH;
        end
      end
      DRAIN: begin
        strobe = 1'b1;
        if (p_ready) begin
          inflight_d = 1'b0;
          state_d    = FETCH;
        end
      end
      HALT:    state_d = HALT;
      default: state_d = BOOT;
    endcase

    // A redirect squashes everything buffered; a request still waiting on the cache must drain first.
    if (state_q != BOOT && redirect_valid) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
      pc_d         = redirect_pc;
      if (strobe && !p_ready) begin
        state_d    = DRAIN;
        inflight_d = 1'b1;
        fa_d       = req_a;
      end else begin
        state_d    = FETCH;
        inflight_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= BOOT;
      pc_q         <= RESET_PC;
      fa_q         <= '0;
      inflight_q   <= 1'b0;
      skid_inst_q  <= '0;
      skid_pc_q    <= '0;
      skid_valid_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_inst_q   <= '0;
      out_pc_q     <= '0;
      out_adel_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      fa_q         <= fa_d;
      inflight_q   <= inflight_d;
      skid_inst_q  <= skid_inst_d;
      skid_pc_q    <= skid_pc_d;
      skid_valid_q <= skid_valid_d;
      out_valid_q  <= out_valid_d;
      out_inst_q   <= out_inst_d;
      out_pc_q     <= out_pc_d;
      out_adel_q   <= out_adel_d;
    end
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter A_WIDTH, default 32: fetch address width.
REQ-002 Parameter RESET_PC, default 32'hBFC0_0000: first fetch address after reset.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 p_a  out  A_WIDTH  fetch address to instruction cache.
REQ-006 p_strobe  out  1  fetch request to instruction cache.
REQ-007 p_din  in  32  instruction returned by cache.
REQ-008 p_ready  in  1  cache result valid this cycle; may be high in the same cycle as p_strobe (hit).
REQ-009 stall  in  1  decode cannot accept this cycle.
REQ-010 redirect_valid  in  1  branch/exception redirect, single-cycle pulse.
REQ-011 redirect_pc  in  A_WIDTH  redirect target.
REQ-012 inst_valid  out  1  inst/inst_pc/inst_adel valid to decode.
REQ-013 inst  out  32  fetched instruction.
REQ-014 inst_pc  out  A_WIDTH  address of inst.
REQ-015 inst_adel  out  1  misaligned fetch address flag for inst_pc.

Function
REQ-016 States: BOOT, FETCH, HOLD, DRAIN, HALT; registers pc (next fetch), fa (in-flight address), inflight flag, one-entry skid buffer (data, pc, valid), output register.
REQ-017 Transfer to decode occurs in each cycle with inst_valid=1 and stall=0.
REQ-018 BOOT: p_strobe=0; next state FETCH unconditionally.
REQ-019 FETCH issue condition: inflight=0, skid empty, not (inst_valid & stall), pc[1:0]==2'b00; on issue p_strobe=1, p_a=pc, fa<=pc.
REQ-020 Once p_strobe is asserted, p_strobe and p_a SHALL remain constant until the cycle p_ready=1, regardless of stall.
REQ-021 p_ready with output slot free (inst_valid=0 or stall=0): output<=(p_din, p_a, adel=0), inst_valid<=1, pc<=p_a+4 (mod 2^A_WIDTH), inflight<=0.
REQ-022 p_ready with output slot occupied and stall=1: instruction into skid, pc<=p_a+4, state HOLD, p_strobe=0.
REQ-023 HOLD: when stall=0, skid moves to output register, skid cleared, state FETCH; no issue while in HOLD.
REQ-024 Back-to-back hits SHALL sustain one instruction per cycle with stall=0.
REQ-025 Misaligned pc at issue point: no strobe; output<=(inst=0, inst_pc=pc, adel=1), inst_valid<=1, state HALT.
REQ-026 HALT: p_strobe=0, output held until transferred, then inst_valid<=0; exit only via redirect.
REQ-027 Redirect (any state except BOOT) has priority over all else: output and skid invalidated next cycle, pc<=redirect_pc.
REQ-028 Redirect while p_strobe=1 and p_ready=0: state DRAIN; p_a/p_strobe held at fa until p_ready, returned data discarded, then FETCH.
REQ-029 Redirect in same cycle as p_ready: returned data discarded, state FETCH, next issue at redirect_pc.
REQ-030 Redirect during DRAIN: pc updated to newest redirect_pc, remain DRAIN.
REQ-031 inst_valid/inst/inst_pc/inst_adel change only on a transfer, a new capture, or a redirect; stable while stall=1.

Reset
REQ-032 rst=1 on a clock edge: state BOOT, pc=RESET_PC, fa=0, inflight=0, skid empty, inst_valid=0, inst=0, inst_pc=0, inst_adel=0; p_strobe=0 during and one cycle after reset.
REQ-033 rst asserted mid-miss: strobe dropped next cycle, any later p_ready ignored until FETCH re-entered.

Verification
REQ-034 Reset release, cache always hits with p_din=addr^32'hFFFF_FFFF -> cycle 2 p_a=BFC00000; inst_valid from cycle 3; inst_pc sequence BFC00000, BFC00004, ... one per cycle.
REQ-035 Miss at BFC00008 with p_ready after 5 cycles -> p_a held at BFC00008 all 5 cycles, inst_valid=0 for BFC00008 until capture, no duplicate/skipped PC.
REQ-036 stall=1 for 3 cycles during in-flight miss completing -> skid used, output unchanged, after release inst_pc order preserved, no loss.
REQ-037 redirect_valid with redirect_pc=80000180 during outstanding miss at BFC00010 -> p_a stays BFC00010 until p_ready, data discarded, next p_a=80000180, inst_valid=0 in between.
REQ-038 redirect_pc=80000002 -> no strobe, inst_valid=1 with inst_pc=80000002, inst_adel=1, inst=0; HALT until redirect to 80000000 resumes fetch.
REQ-039 rst pulse mid-stream -> all outputs return to REQ-032 values, fetch restarts at BFC00000.
